// File: rtl/axi_addr_router_if.sv
// Address-channel bundle between an upstream AXI master, the address router
// and the downstream interconnect stage.
interface axi_addr_router_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SLAVE_NUM  = 5
);
  logic                  s_valid;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [SLAVE_NUM-1:0]  m_select;
  logic                  m_decerr;

  // Router side.
  modport slave (
    input  s_valid, s_addr, m_ready,
    output s_ready, m_valid, m_addr, m_select, m_decerr
  );

  // Upstream/downstream environment side.
  modport master (
    output s_valid, s_addr, m_ready,
    input  s_ready, m_valid, m_addr, m_select, m_decerr
  );
endinterface

// File: rtl/axi_addr_router.sv
// Registered base/mask address decoder for one AXI address channel, with an
// outstanding-transaction lock that keeps responses ordered across slaves.
module axi_addr_router #(
  parameter int unsigned                         ADDR_WIDTH      = 32,
  parameter int unsigned                         SLAVE_NUM       = 5,
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0]     SLV_BASE        = {SLAVE_NUM{32'h0}},
  parameter logic [SLAVE_NUM*ADDR_WIDTH-1:0]     SLV_MASK        = {SLAVE_NUM{32'hF000_0000}},
  parameter int unsigned                         MAX_OUTSTANDING = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETn,
  axi_addr_router_if.slave                       bus,
  input  logic                                   rsp_done,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   busy
);
  localparam int unsigned TW = $clog2(SLAVE_NUM + 1);
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         locked_q, locked_d;
  logic                  m_valid_q, m_valid_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [SLAVE_NUM-1:0]  m_select_q, m_select_d;
  logic                  m_decerr_q, m_decerr_d;

  logic [TW-1:0]         target;
  logic                  hit;
  logic [SLAVE_NUM-1:0]  onehot;
  logic                  stall;
  logic                  s_ready_c;
  logic                  accept;
  logic                  dec;

  // Lowest-index window wins; no hit falls through to the DECERR code.
  always_comb begin
    target = TW'(SLAVE_NUM);
    hit    = 1'b0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (!hit && ((bus.s_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   (SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))) begin
        target = TW'(i);
        hit    = 1'b1;
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      if (target == TW'(i)) onehot[i] = 1'b1;
    end
  end

  always_comb begin
    stall     = (cnt_q == CW'(MAX_OUTSTANDING)) ||
                ((state_q == ACTIVE) && (target != locked_q));
    s_ready_c = (!m_valid_q || bus.m_ready) && !stall;
    accept    = bus.s_valid && s_ready_c;
    // A completion with nothing outstanding is dropped rather than wrapping.
    dec       = rsp_done && (cnt_q != '0);

    cnt_d = cnt_q;
    if (accept && !dec)      cnt_d = cnt_q + CW'(1);
    else if (!accept && dec) cnt_d = cnt_q - CW'(1);

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE:  if (cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    locked_d   = locked_q;
    m_valid_d  = m_valid_q;
    m_addr_d   = m_addr_q;
    m_select_d = m_select_q;
    m_decerr_d = m_decerr_q;
    if (accept) begin
      locked_d   = target;
      m_valid_d  = 1'b1;
      m_addr_d   = bus.s_addr;
      m_select_d = onehot;
      m_decerr_d = (target == TW'(SLAVE_NUM));
    end else if (bus.m_ready) begin
      m_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      locked_q   <= TW'(SLAVE_NUM);
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_select_q <= '0;
      m_decerr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      locked_q   <= locked_d;
      m_valid_q  <= m_valid_d;
      m_addr_q   <= m_addr_d;
      m_select_q <= m_select_d;
      m_decerr_q <= m_decerr_d;
    end
  end

  assign bus.s_ready  = s_ready_c;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_select = m_select_q;
  assign bus.m_decerr = m_decerr_q;
  assign outstanding  = cnt_q;
  assign busy         = (cnt_q != '0);
endmodule

// File: doc/axi_addr_router.md
Name: axi_addr_router

Overview:
- Parametrised, registered address decoder for one AXI address channel (AR or AW). One instance per channel.
- Each address is matched against per-slave base/mask windows. Unmatched addresses go to an internal DECERR target.
- Outputs a one-hot slave select on a registered valid/ready stage.
- Tracks outstanding transactions. New traffic to a different target stalls until earlier responses drain, which preserves AXI response ordering across slaves.

Parameters:
- ADDR_WIDTH, 32, address width in bits.
- SLAVE_NUM, 5, number of slave windows (1..16).
- SLV_BASE, {SLAVE_NUM{32'h0}}, packed SLAVE_NUM*ADDR_WIDTH vector of window base addresses; slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLV_MASK, {SLAVE_NUM{32'hF000_0000}}, packed vector of window masks, same layout.
- MAX_OUTSTANDING, 4, maximum accepted-but-unresponded transactions (1..15).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- s_valid  in  1  upstream address valid.
- s_ready  out  1  upstream address ready.
- s_addr  in  ADDR_WIDTH  upstream address.
- m_valid  out  1  decoded request valid.
- m_ready  in  1  downstream ready.
- m_addr  out  ADDR_WIDTH  registered address.
- m_select  out  SLAVE_NUM  one-hot slave select; all zero on DECERR.
- m_decerr  out  1  request targets the default (error) slave.
- rsp_done  in  1  single-cycle pulse: one transaction's final response has completed.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.
- busy  out  1  outstanding != 0.

Behaviour:
- Clock/reset: one clock, ACLK. ARESETn is asynchronous, active-low.
- Reset values: m_valid=0, m_addr=0, m_select=0, m_decerr=0, outstanding=0, busy=0, locked target=DECERR code. s_ready is combinational and evaluates to 1 after reset.
- Decode (combinational on s_addr):
  - Slave i matches when (s_addr & MASK_i) == (BASE_i & MASK_i).
  - Multiple matches: the lowest index wins.
  - No match: target code = SLAVE_NUM, i.e. DECERR.
  - Target code width is $clog2(SLAVE_NUM+1).
- State machine, IDLE / ACTIVE:
  - IDLE when outstanding==0; ACTIVE otherwise.
  - IDLE -> ACTIVE on any accept.
  - ACTIVE -> IDLE when the count reaches 0.
- Accept condition: s_ready = (!m_valid || m_ready) && !stall, where stall = (outstanding == MAX_OUTSTANDING) || (state==ACTIVE && target != locked).
- In IDLE, any target is accepted.
- Accept (s_valid && s_ready):
  - Next cycle: m_valid=1, m_addr=s_addr, m_select=onehot(target) (0 for DECERR), m_decerr=(target==SLAVE_NUM).
  - locked <= target.
  - Latency is exactly 1 cycle from accept to m_valid.
- Output stage:
  - m_valid, m_addr, m_select and m_decerr are held stable while m_valid && !m_ready.
  - The stage clears to m_valid=0 on an m handshake with no concurrent accept.
  - Back-to-back accept with m_ready=1 sustains 1 transfer/cycle.
- Counter:
  - +1 on accept, -1 on rsp_done.
  - Both in the same cycle: count unchanged.
  - rsp_done while count==0 is ignored: count stays 0, no underflow.
  - The count never exceeds MAX_OUTSTANDING.
- Stall boundaries:
  - A stall evaluates combinationally in the same cycle rsp_done decrements. The decrement takes effect next cycle, so the stalled request is accepted one cycle after count reaches 0, or after count drops below MAX.
  - s_valid deasserting while stalled is permitted; no state changes.
- Reset mid-operation: all state clears immediately. In-flight m_valid drops; the counter zeroes.

Test Plan (SLAVE_NUM=5; slave i base = i*32'h1000_0000; all masks 32'hF000_0000; MAX_OUTSTANDING=4):
- Basic decode:
  - Stimulus: s_addr=32'h2000_0040 accepted at cycle N.
  - Required: cycle N+1 m_valid=1, m_select=5'b00100, m_decerr=0, m_addr=32'h2000_0040, outstanding=1.
- DECERR:
  - Stimulus: s_addr=32'h7000_0000.
  - Required: m_select=5'b00000, m_decerr=1; locked=5. A following 32'h7100_0000 is accepted without stall.
- Ordering stall:
  - Stimulus: accept 32'h1000_0000, then present 32'h3000_0000 with no rsp_done.
  - Required: s_ready=0 while outstanding=1.
  - Then pulse rsp_done: next cycle outstanding=0, s_ready=1, m_select=5'b01000 one cycle after accept.
- Max outstanding:
  - Stimulus: 4 back-to-back accepts to slave 0 with m_ready=1 and no rsp_done.
  - Required: outstanding=4 and s_ready=0 for the 5th request. One rsp_done yields outstanding=3 and the 5th is accepted the following cycle.
- Backpressure plus simultaneous events:
  - Stimulus: hold m_ready=0 for 3 cycles. In the cycle of an accept, also pulse rsp_done.
  - Required: m_* outputs stay constant during backpressure; outstanding is unchanged across the simultaneous +1/-1.
  - Stimulus: rsp_done at count 0. Required: count stays 0.
- Async reset:
  - Stimulus: assert ARESETn=0 mid-stream with outstanding=2 and m_valid=1.
  - Required: m_valid=0, outstanding=0, busy=0 immediately, without waiting for an ACLK edge. The first post-reset request to any slave is accepted.
